// File: rtl/kt_pkg.sv
// Shared types and constants for the KnightsTour command scheduler.
// Holds the FSM state enum, opcodes, headings, response bytes and leg bundle.
package kt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLDV,
    HORZ,
    HOLDH
  } state_e;

  localparam logic [3:0] CMD_MOVE    = 4'b0010;
  localparam logic [3:0] CMD_MOVE_FF = 4'b0011;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_POS_ACK = 8'hA5;
  localparam logic [7:0] RESP_INTERIM = 8'h5A;

  typedef struct packed {
    logic [7:0] vert_hdg;
    logic [3:0] vert_sq;
    logic [7:0] horz_hdg;
    logic [3:0] horz_sq;
    logic       illegal;
  } leg_t;

endpackage

// File: rtl/tour_cmd_sched_if.sv
// Command-path bundle between UART side, scheduler and cmd_proc.
// master: the scheduler; slave: the surrounding UART/cmd_proc logic.
interface tour_cmd_sched_if;

  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART,
    input  clr_cmd_rdy, send_resp,
    output cmd, cmd_rdy, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART,
    output clr_cmd_rdy, send_resp,
    input  cmd, cmd_rdy, resp
  );

endinterface

// File: rtl/move_decode.sv
// One-hot L-move to vertical/horizontal leg headings and square counts.
// Anything that is not exactly one-hot is flagged illegal.
module move_decode
  import kt_pkg::*;
(
  input  logic [7:0] move_i,
  output leg_t       leg_o
);

  // north: b0 b1 b2 b7; two rows: b0 b1 b4 b5
  // east:  b0 b5 b6 b7; two cols: b2 b3 b6 b7
  always_comb begin
    leg_o.vert_hdg = |(move_i & 8'h87) ? HDG_N : HDG_S;
    leg_o.vert_sq  = |(move_i & 8'h33) ? 4'd2 : 4'd1;
    leg_o.horz_hdg = |(move_i & 8'hE1) ? HDG_E : HDG_W;
    leg_o.horz_sq  = |(move_i & 8'hCC) ? 4'd2 : 4'd1;
    leg_o.illegal  = ~$onehot(move_i);
  end

endmodule

// File: rtl/tour_cmd_sched.sv
// Replays a solved knight's tour to cmd_proc, else passes UART cmds through.
// Build macro TOUR_FANFARE_EN selects the fanfare opcode for horizontal legs.
module tour_cmd_sched
  import kt_pkg::*;
#(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  output logic             tour_done,
  output logic             tour_err,
  tour_cmd_sched_if.master bus
);

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] HORZ_OP = CMD_MOVE_FF;
`else
  localparam logic [3:0] HORZ_OP = CMD_MOVE;
`endif

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MOVES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  leg_t             leg;

  move_decode u_dec (
    .move_i (move),
    .leg_o  (leg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    bus.cmd     = 16'h0000;
    bus.cmd_rdy = 1'b0;
    bus.resp    = RESP_INTERIM;
    unique case (state_q)
      IDLE: begin
        bus.cmd  = bus.cmd_UART;
        bus.resp = RESP_POS_ACK;
        // a UART cmd colliding with start stays pending until tour ends
        bus.cmd_rdy = bus.cmd_rdy_UART & ~start_tour;
        if (start_tour) begin
          state_d = VERT;
          idx_d   = '0;
        end
      end
      VERT: begin
        if (leg.illegal) begin
          err_d   = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          bus.cmd     = {CMD_MOVE, leg.vert_hdg, leg.vert_sq};
          bus.cmd_rdy = 1'b1;
          if (bus.clr_cmd_rdy) state_d = HOLDV;
        end
      end
      HOLDV: begin
        if (bus.send_resp) state_d = HORZ;
      end
      HORZ: begin
        bus.cmd     = {HORZ_OP, leg.horz_hdg, leg.horz_sq};
        bus.cmd_rdy = 1'b1;
        if (bus.clr_cmd_rdy) state_d = HOLDH;
      end
      HOLDH: begin
        if (bus.send_resp) begin
          if (idx_q == LAST) begin
            state_d  = IDLE;
            idx_d    = '0;
            done_d   = 1'b1;
            bus.resp = RESP_POS_ACK;
          end else begin
            state_d = VERT;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mv_indx   = idx_q;
  assign tour_done = done_q;
  assign tour_err  = err_q;

endmodule
